// File: rtl/raster_setup_ctrl.sv
// Triangle setup sequencer: drives the edge setup unit, culls and clips,
// then hands accepted triangles to the rasterizer.
module raster_setup_ctrl #(
  parameter int SCR_W     = 256,
  parameter int SCR_H     = 128,
  parameter int CAP_DELAY = 1,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tri_valid,
  output logic        tri_ready,
  input  logic [8:0]  tri_v1x,
  input  logic [8:0]  tri_v2x,
  input  logic [8:0]  tri_v3x,
  input  logic [7:0]  tri_v1y,
  input  logic [7:0]  tri_v2y,
  input  logic [7:0]  tri_v3y,
  input  logic        cull_en,
  output logic [8:0]  eu_v1x,
  output logic [8:0]  eu_v2x,
  output logic [8:0]  eu_v3x,
  output logic [7:0]  eu_v1y,
  output logic [7:0]  eu_v2y,
  output logic [7:0]  eu_v3y,
  output logic        eu_start,
  input  logic        eu_done,
  input  logic [9:0]  eu_a1,
  input  logic [9:0]  eu_b1,
  input  logic [9:0]  eu_a2,
  input  logic [9:0]  eu_b2,
  input  logic [9:0]  eu_a3,
  input  logic [9:0]  eu_b3,
  input  logic [17:0] eu_c1,
  input  logic [17:0] eu_c2,
  input  logic [17:0] eu_c3,
  input  logic [8:0]  eu_bbxi,
  input  logic [8:0]  eu_bbxf,
  input  logic [7:0]  eu_bbyi,
  input  logic [7:0]  eu_bbyf,
  output logic        ras_valid,
  input  logic        ras_ready,
  output logic [9:0]  ras_a1,
  output logic [9:0]  ras_b1,
  output logic [9:0]  ras_a2,
  output logic [9:0]  ras_b2,
  output logic [9:0]  ras_a3,
  output logic [9:0]  ras_b3,
  output logic [17:0] ras_c1,
  output logic [17:0] ras_c2,
  output logic [17:0] ras_c3,
  output logic [8:0]  ras_bbxi,
  output logic [8:0]  ras_bbxf,
  output logic [7:0]  ras_bbyi,
  output logic [7:0]  ras_bbyf,
  output logic [15:0] tri_count,
  output logic [15:0] cull_count,
  output logic        err_timeout
);

  localparam int CW = $clog2(TIMEOUT) + 2;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] DL_LAST =
    CW'((CAP_DELAY > 0) ? CAP_DELAY - 1 : 0);
  localparam logic signed [9:0] XMAX = 10'(SCR_W - 1);
  localparam logic signed [8:0] YMAX = 9'(SCR_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DELAY,
    S_CAPTURE,
    S_OUT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic signed [19:0] area;
  logic signed [9:0]  bxi;
  logic signed [9:0]  bxf;
  logic signed [8:0]  byi;
  logic signed [8:0]  byf;
  logic               offscreen;
  logic               cull;
  logic [8:0]         clip_xi;
  logic [8:0]         clip_xf;
  logic [7:0]         clip_yi;
  logic [7:0]         clip_yf;

  assign tri_ready = (state == S_IDLE);

  // Capture and the cull decision share one cycle to meet the latency target
  always_comb begin
    area = {{2{eu_c1[17]}}, eu_c1}
         + {{2{eu_c2[17]}}, eu_c2}
         + {{2{eu_c3[17]}}, eu_c3};
    bxi = {eu_bbxi[8], eu_bbxi};
    bxf = {eu_bbxf[8], eu_bbxf};
    byi = {eu_bbyi[7], eu_bbyi};
    byf = {eu_bbyf[7], eu_bbyf};
    offscreen = bxf[9] || (bxi > XMAX)
             || byf[8] || (byi > YMAX);
    cull = (area == 20'sd0)
        || (cull_en && area[19])
        || offscreen;
    clip_xi = bxi[9] ? 9'd0 : bxi[8:0];
    clip_xf = (bxf > XMAX) ? XMAX[8:0] : bxf[8:0];
    clip_yi = byi[8] ? 8'd0 : byi[7:0];
    clip_yf = (byf > YMAX) ? YMAX[7:0] : byf[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      eu_v1x      <= '0;
      eu_v2x      <= '0;
      eu_v3x      <= '0;
      eu_v1y      <= '0;
      eu_v2y      <= '0;
      eu_v3y      <= '0;
      eu_start    <= 1'b0;
      ras_valid   <= 1'b0;
      ras_a1      <= '0;
      ras_b1      <= '0;
      ras_a2      <= '0;
      ras_b2      <= '0;
      ras_a3      <= '0;
      ras_b3      <= '0;
      ras_c1      <= '0;
      ras_c2      <= '0;
      ras_c3      <= '0;
      ras_bbxi    <= '0;
      ras_bbxf    <= '0;
      ras_bbyi    <= '0;
      ras_bbyf    <= '0;
      tri_count   <= '0;
      cull_count  <= '0;
      err_timeout <= 1'b0;
    end else begin
      eu_start    <= 1'b0;
      err_timeout <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (tri_valid) begin
            eu_v1x   <= tri_v1x;
            eu_v2x   <= tri_v2x;
            eu_v3x   <= tri_v3x;
            eu_v1y   <= tri_v1y;
            eu_v2y   <= tri_v2y;
            eu_v3y   <= tri_v3y;
            eu_start <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (eu_done) begin
            cnt   <= '0;
            state <= (CAP_DELAY == 0) ? S_CAPTURE : S_DELAY;
          end else if (cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DELAY: begin
          if (cnt == DL_LAST) state <= S_CAPTURE;
          else                cnt   <= cnt + 1'b1;
        end
        S_CAPTURE: begin
          ras_a1   <= eu_a1;
          ras_b1   <= eu_b1;
          ras_a2   <= eu_a2;
          ras_b2   <= eu_b2;
          ras_a3   <= eu_a3;
          ras_b3   <= eu_b3;
          ras_c1   <= eu_c1;
          ras_c2   <= eu_c2;
          ras_c3   <= eu_c3;
          ras_bbxi <= clip_xi;
          ras_bbxf <= clip_xf;
          ras_bbyi <= clip_yi;
          ras_bbyf <= clip_yf;
          if (cull) begin
            cull_count <= cull_count + 16'd1;
            state      <= S_IDLE;
          end else begin
            ras_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (ras_ready) begin
            ras_valid <= 1'b0;
            tri_count <= tri_count + 16'd1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_setup_ctrl.sv
// Randomized bench for raster_setup_ctrl with a stub setup unit and
// a vertex-level reference model of setup, culling and clipping.
module tb_raster_setup_ctrl;

  localparam int SCR_W     = 256;
  localparam int SCR_H     = 128;
  localparam int CAP_DELAY = 1;
  localparam int TIMEOUT   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        tri_valid;
  logic        tri_ready;
  logic [8:0]  tri_v1x, tri_v2x, tri_v3x;
  logic [7:0]  tri_v1y, tri_v2y, tri_v3y;
  logic        cull_en;
  logic [8:0]  eu_v1x, eu_v2x, eu_v3x;
  logic [7:0]  eu_v1y, eu_v2y, eu_v3y;
  logic        eu_start;
  logic        eu_done;
  logic [9:0]  eu_a1, eu_b1, eu_a2, eu_b2, eu_a3, eu_b3;
  logic [17:0] eu_c1, eu_c2, eu_c3;
  logic [8:0]  eu_bbxi, eu_bbxf;
  logic [7:0]  eu_bbyi, eu_bbyf;
  logic        ras_valid;
  logic        ras_ready;
  logic [9:0]  ras_a1, ras_b1, ras_a2, ras_b2, ras_a3, ras_b3;
  logic [17:0] ras_c1, ras_c2, ras_c3;
  logic [8:0]  ras_bbxi, ras_bbxf;
  logic [7:0]  ras_bbyi, ras_bbyf;
  logic [15:0] tri_count, cull_count;
  logic        err_timeout;

  int n_cmp = 0;
  int n_err = 0;
  int exp_tri = 0;
  int exp_cull = 0;

  int ea[3], eb[3], ec[3];
  int exi, exf, eyi, eyf;
  int vx[3], vy[3];

  raster_setup_ctrl #(
    .SCR_W(SCR_W), .SCR_H(SCR_H),
    .CAP_DELAY(CAP_DELAY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_v1x(tri_v1x), .tri_v2x(tri_v2x), .tri_v3x(tri_v3x),
    .tri_v1y(tri_v1y), .tri_v2y(tri_v2y), .tri_v3y(tri_v3y),
    .cull_en(cull_en),
    .eu_v1x(eu_v1x), .eu_v2x(eu_v2x), .eu_v3x(eu_v3x),
    .eu_v1y(eu_v1y), .eu_v2y(eu_v2y), .eu_v3y(eu_v3y),
    .eu_start(eu_start), .eu_done(eu_done),
    .eu_a1(eu_a1), .eu_b1(eu_b1), .eu_a2(eu_a2),
    .eu_b2(eu_b2), .eu_a3(eu_a3), .eu_b3(eu_b3),
    .eu_c1(eu_c1), .eu_c2(eu_c2), .eu_c3(eu_c3),
    .eu_bbxi(eu_bbxi), .eu_bbxf(eu_bbxf),
    .eu_bbyi(eu_bbyi), .eu_bbyf(eu_bbyf),
    .ras_valid(ras_valid), .ras_ready(ras_ready),
    .ras_a1(ras_a1), .ras_b1(ras_b1), .ras_a2(ras_a2),
    .ras_b2(ras_b2), .ras_a3(ras_a3), .ras_b3(ras_b3),
    .ras_c1(ras_c1), .ras_c2(ras_c2), .ras_c3(ras_c3),
    .ras_bbxi(ras_bbxi), .ras_bbxf(ras_bbxf),
    .ras_bbyi(ras_bbyi), .ras_bbyf(ras_bbyf),
    .tri_count(tri_count), .cull_count(cull_count),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero_state(input string pfx);
    chk({pfx, "_euv"},
        {eu_v1x, eu_v2x, eu_v3x, eu_v1y, eu_v2y, eu_v3y}, 64'd0);
    chk({pfx, "_ab"},
        {ras_a1, ras_b1, ras_a2, ras_b2, ras_a3, ras_b3}, 64'd0);
    chk({pfx, "_c"}, {ras_c1, ras_c2, ras_c3}, 64'd0);
    chk({pfx, "_bb"},
        {ras_bbxi, ras_bbxf, ras_bbyi, ras_bbyf}, 64'd0);
    chk({pfx, "_ctl"},
        {eu_start, ras_valid, err_timeout, tri_count, cull_count},
        64'd0);
    chk({pfx, "_rdy"}, tri_ready, 1);
  endtask

  task automatic chk_ras(input string pfx);
    chk({pfx, "_a1"}, $signed(ras_a1), ea[0]);
    chk({pfx, "_b1"}, $signed(ras_b1), eb[0]);
    chk({pfx, "_a2"}, $signed(ras_a2), ea[1]);
    chk({pfx, "_b2"}, $signed(ras_b2), eb[1]);
    chk({pfx, "_a3"}, $signed(ras_a3), ea[2]);
    chk({pfx, "_b3"}, $signed(ras_b3), eb[2]);
    chk({pfx, "_c1"}, $signed(ras_c1), ec[0]);
    chk({pfx, "_c2"}, $signed(ras_c2), ec[1]);
    chk({pfx, "_c3"}, $signed(ras_c3), ec[2]);
    chk({pfx, "_bbx"}, {ras_bbxi, ras_bbxf}, {9'(exi), 9'(exf)});
    chk({pfx, "_bby"}, {ras_bbyi, ras_bbyf}, {8'(eyi), 8'(eyf)});
  endtask

  // Model: edge i runs from vertex i to vertex i+1; c sum is twice the area
  task automatic model(input int x1, y1, x2, y2, x3, y3,
                       input bit ce, output bit culled);
    int area, bxi, bxf, byi, byf;
    bit off;
    vx = '{x1, x2, x3};
    vy = '{y1, y2, y3};
    for (int i = 0; i < 3; i++) begin
      int j = (i + 1) % 3;
      ea[i] = vy[i] - vy[j];
      eb[i] = vx[j] - vx[i];
      ec[i] = vx[i] * vy[j] - vx[j] * vy[i];
    end
    area = ec[0] + ec[1] + ec[2];
    bxi = vx[0]; bxf = vx[0]; byi = vy[0]; byf = vy[0];
    for (int i = 1; i < 3; i++) begin
      if (vx[i] < bxi) bxi = vx[i];
      if (vx[i] > bxf) bxf = vx[i];
      if (vy[i] < byi) byi = vy[i];
      if (vy[i] > byf) byf = vy[i];
    end
    off = bxf < 0 || bxi > SCR_W - 1 || byf < 0 || byi > SCR_H - 1;
    culled = area == 0 || (ce && area < 0) || off;
    exi = bxi < 0 ? 0 : bxi;
    exf = bxf > SCR_W - 1 ? SCR_W - 1 : bxf;
    eyi = byi < 0 ? 0 : byi;
    eyf = byf > SCR_H - 1 ? SCR_H - 1 : byf;
    eu_a1 = 10'(ea[0]); eu_b1 = 10'(eb[0]);
    eu_a2 = 10'(ea[1]); eu_b2 = 10'(eb[1]);
    eu_a3 = 10'(ea[2]); eu_b3 = 10'(eb[2]);
    eu_c1 = 18'(ec[0]); eu_c2 = 18'(ec[1]); eu_c3 = 18'(ec[2]);
    eu_bbxi = 9'(bxi); eu_bbxf = 9'(bxf);
    eu_bbyi = 8'(byi); eu_bbyf = 8'(byf);
  endtask

  // Returns positioned #1 into cycle 1 (the cycle after acceptance)
  task automatic start_tri(input bit ce);
    int n = 0;
    tri_v1x = 9'(vx[0]); tri_v2x = 9'(vx[1]); tri_v3x = 9'(vx[2]);
    tri_v1y = 8'(vy[0]); tri_v2y = 8'(vy[1]); tri_v3y = 8'(vy[2]);
    cull_en = ce;
    eu_done = 1'b0;
    ras_ready = 1'b0;
    tri_valid = 1'b1;
    while (tri_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_rdy", tri_ready, 1);
    @(posedge clk); #1;
    tri_valid = 1'b0;
  endtask

  task automatic run_tri(input int x1, y1, x2, y2, x3, y3,
                         input bit ce, input int done_at,
                         input int hold, input bit busy, input bit spur);
    bit culled;
    int dv;
    model(x1, y1, x2, y2, x3, y3, ce, culled);
    start_tri(ce);
    dv = done_at + CAP_DELAY + 2;
    for (int k = 1; k < 80; k++) begin
      if (done_at == 0) eu_done = 1'b0;
      else eu_done = (k == done_at) || (spur && (k == 1 || k > done_at));
      ras_ready = (done_at != 0) && (k >= dv + hold);
      if (busy && k >= dv && k < dv + hold) begin
        tri_valid = 1'b1;
        tri_v1x = 9'h0AA; tri_v1y = 8'h55;
      end else begin
        tri_valid = 1'b0;
      end
      @(negedge clk);
      if (k == 1) begin
        chk("start", eu_start, 1);
        chk("busy_rdy", tri_ready, 0);
      end
      if (k == 1 || (busy && k >= dv && k < dv + hold))
        chk("eu_v",
            {eu_v1x, eu_v2x, eu_v3x, eu_v1y, eu_v2y, eu_v3y},
            {9'(vx[0]), 9'(vx[1]), 9'(vx[2]),
             8'(vy[0]), 8'(vy[1]), 8'(vy[2])});
      if (k == 2) chk("start_pulse", eu_start, 0);
      if (done_at == 0) begin
        if (k >= 2) chk("err_to", err_timeout, k == 2 + TIMEOUT);
        if (k == 2 + TIMEOUT) chk("to_rdy", tri_ready, 1);
        if (k == 3 + TIMEOUT) begin
          chk("to_cnt", {tri_count, cull_count},
              {16'(exp_tri), 16'(exp_cull)});
          @(posedge clk); #1;
          return;
        end
      end else begin
        if (k < dv) chk("early_valid", ras_valid, 0);
        if (k == dv && culled) begin
          exp_cull++;
          chk("cull_valid", ras_valid, 0);
          chk("cull_cnt", {tri_count, cull_count},
              {16'(exp_tri), 16'(exp_cull)});
          chk("cull_rdy", tri_ready, 1);
          @(posedge clk); #1;
          return;
        end
        if (!culled && k == dv) begin
          chk("valid_lat", ras_valid, 1);
          chk("no_err", err_timeout, 0);
          chk_ras("out");
        end
        if (!culled && k > dv && k <= dv + hold) begin
          chk("hold_valid", ras_valid, 1);
          chk("hold_rdy", tri_ready, 0);
          chk_ras("hold");
        end
        if (!culled && k == dv + hold + 1) begin
          exp_tri++;
          chk("post_valid", ras_valid, 0);
          chk("post_rdy", tri_ready, 1);
          chk("emit_cnt", {tri_count, cull_count},
              {16'(exp_tri), 16'(exp_cull)});
          @(posedge clk); #1;
          return;
        end
      end
      @(posedge clk); #1;
    end
    chk("cycle_budget", 0, 1);
  endtask

  task automatic rand_vtx(output int x, output int y);
    x = int'($urandom_range(0, 319)) - 64;
    y = int'($urandom_range(0, 159)) - 32;
  endtask

  initial begin
    bit dummy;
    int x[3], y[3];
    rst = 1'b1;
    tri_valid = 1'b0;
    cull_en = 1'b0;
    eu_done = 1'b0;
    ras_ready = 1'b0;
    {tri_v1x, tri_v2x, tri_v3x} = '0;
    {tri_v1y, tri_v2y, tri_v3y} = '0;
    model(0, 0, 0, 0, 0, 0, 1'b0, dummy);
    repeat (3) @(posedge clk);
    #1;
    chk_zero_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_tri(10, 10, 50, 10, 10, 40, 1, 3, 0, 0, 0);
    run_tri(10, 10, 10, 40, 50, 10, 1, 3, 0, 0, 0);
    run_tri(10, 10, 10, 40, 50, 10, 0, 3, 0, 0, 0);
    run_tri(0, 0, 10, 10, 20, 20, 0, 3, 0, 0, 0);
    run_tri(-20, -10, 100, -10, -20, 100, 1, 3, 0, 0, 1);
    run_tri(-50, -50, -10, -50, -50, -10, 1, 3, 0, 0, 0);
    run_tri(300 - 64, 120, 255, 127, 240, 100, 0, 2, 5, 1, 0);
    run_tri(20, 20, 80, 20, 20, 90, 1, 0, 0, 0, 0);

    // Reset while waiting on the setup unit
    model(5, 5, 60, 5, 5, 60, 1'b1, dummy);
    start_tri(1'b1);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero_state("rst_wait");
    exp_tri = 0;
    exp_cull = 0;

    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 3; i++) rand_vtx(x[i], y[i]);
      run_tri(x[0], y[0], x[1], y[1], x[2], y[2],
              1'($urandom_range(0, 1)),
              (t % 15 == 14) ? 0 : int'($urandom_range(2, 9)),
              int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/raster_setup_ctrl.md
Name: raster_setup_ctrl

Overview:
- Sequences the triangle setup unit (edge-equation coefficients plus bounding box) for each incoming triangle.
- Accepts screen-space vertices over a valid/ready handshake and drives the setup unit's start/done handshake.
- Captures the setup unit's outputs, computes signed area, culls degenerate, back-facing and off-screen triangles, and clips the bounding box to the screen.
- Presents accepted triangles to the rasterizer over a valid/ready handshake.

Parameters:
- SCR_W, 256, screen width in pixels; legal range 1..256.
- SCR_H, 128, screen height in pixels; legal range 1..128.
- CAP_DELAY, 1, cycles between first eu_done sampled high and coefficient capture; legal range 0..3.
- TIMEOUT, 16, maximum cycles spent in WAIT before abort.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- tri_valid  in  1  upstream triangle valid
- tri_ready  out  1  high only in IDLE
- tri_v1x, tri_v2x, tri_v3x  in  9 each  signed vertex x
- tri_v1y, tri_v2y, tri_v3y  in  8 each  signed vertex y
- cull_en  in  1  enables back-face culling
- eu_v1x..eu_v3x / eu_v1y..eu_v3y  out  9/8  vertices to setup unit, registered
- eu_start  out  1  one-cycle start pulse
- eu_done  in  1  setup unit done
- eu_a1, eu_b1, eu_a2, eu_b2, eu_a3, eu_b3  in  10 each  signed coefficients
- eu_c1, eu_c2, eu_c3  in  18 each  signed coefficients
- eu_bbxi, eu_bbxf  in  9  bbox x, interpreted as signed
- eu_bbyi, eu_bbyf  in  8  bbox y, interpreted as signed
- ras_valid  out  1  triangle available to rasterizer
- ras_ready  in  1  rasterizer accepts
- ras_a1..ras_b3 / ras_c1..ras_c3  out  10/18  captured coefficients
- ras_bbxi, ras_bbxf  out  9  clipped bbox x, unsigned
- ras_bbyi, ras_bbyf  out  8  clipped bbox y, unsigned
- tri_count, cull_count  out  16 each  emitted and culled triangle counters
- err_timeout  out  1  one-cycle pulse when WAIT aborts

Behaviour:
- Reset: state=IDLE; every output register, both counters, eu_start, ras_valid and err_timeout are 0. rst has priority over all other events, mid-triangle included; an in-flight triangle is discarded.
- IDLE: tri_ready=1. On tri_valid, register the vertices onto eu_v* and go to START. eu_v* hold until the next acceptance.
- START: eu_start=1 for exactly one cycle, then WAIT.
- WAIT: a counter increments each cycle.
  - On the first cycle eu_done=1, go to DELAY (or directly to CAPTURE if CAP_DELAY=0).
  - If the counter reaches TIMEOUT with no eu_done, pulse err_timeout and return to IDLE. The triangle is dropped and neither counter changes.
- DELAY: wait CAP_DELAY cycles, then CAPTURE. eu_done is ignored here.
- CAPTURE: register all a/b/c values.
  - area = eu_c1+eu_c2+eu_c3, sign-extended to 20 bits.
  - Clip: xi=max(bbxi,0), xf=min(bbxf,SCR_W-1); y likewise against SCR_H-1.
  - offscreen = bbxf<0 or bbxi>SCR_W-1 or bbyf<0 or bbyi>SCR_H-1.
- DECIDE: cull if area==0, or (cull_en and area<0), or offscreen.
  - On cull: cull_count+1, go to IDLE.
  - Otherwise go to OUT.
- OUT: ras_valid=1 with all ras_* held stable until ras_valid&ras_ready. On that handshake: tri_count+1, ras_valid=0 the next cycle, go to IDLE.
- Latency: with handshake at cycle 0 and eu_done high at cycle 3, ras_valid is high from cycle 4+CAP_DELAY+1, i.e. cycle 6 at defaults. The next tri_ready is the cycle after the ras handshake.
- Counters wrap 0xFFFF→0. Only one triangle is in flight; there is no overlap.
- A spurious eu_done in IDLE, START, OUT or DECIDE is ignored.

Test Plan:
- (10,10),(50,10),(10,40), cull_en=1, ras_ready=1 -> ras_valid at cycle 6; a1=0, b1=40, c1=-400; bbox x 10..50, y 10..40; tri_count=1.
- (10,10),(10,40),(50,10): with cull_en=1, area=-1200 -> no ras_valid, cull_count=1. With cull_en=0 -> emitted.
- (0,0),(10,10),(20,20) with cull_en=0 -> area 0, culled, cull_count+1.
- (-20,-10),(100,-10),(-20,100) -> area=13200, emitted bbox x 0..100, y 0..100. (-50,-50),(-10,-50),(-50,-10) -> offscreen, culled.
- ras_ready held low 5 cycles in OUT -> ras_* stable, tri_ready=0, a second tri_valid not accepted; accepted one cycle after the handshake.
- Stubbed eu_done=0 -> err_timeout pulse after 16 WAIT cycles, return to IDLE, counters unchanged. rst asserted in WAIT -> IDLE next cycle, all outputs 0.
